// File: rtl/k6502_pkg.sv
// k6502_pkg: shared cycle constants, reset length, NOP opcode and per-opcode timing record
package k6502_pkg;
  localparam logic [2:0] T_RESET = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;
  localparam logic [2:0] T7 = 3'd7;
  localparam int RESET_SEQ_LEN = 7;
  localparam logic [7:0] OPC_NOP = 8'hEA;
  typedef struct packed {
    logic [2:0] len;
    logic       idx_read;
    logic       branch;
  } cycle_info_t;
endpackage

// File: rtl/k6502_timing_if.sv
// k6502_timing_if: bus between the timing generator and its environment
// master drives d/rdy/page_cross/branch_taken and observes the phase, sync, ir,
// t_state and in_reset outputs; slave is the timing generator side.
interface k6502_timing_if;
  logic [7:0] d;
  logic       rdy;
  logic       page_cross;
  logic       branch_taken;
  logic       ph1;
  logic       ph2;
  logic       sync;
  logic [7:0] ir;
  logic [2:0] t_state;
  logic       in_reset;
  modport master (
    output d, rdy, page_cross, branch_taken,
    input  ph1, ph2, sync, ir, t_state, in_reset
  );
  modport slave (
    input  d, rdy, page_cross, branch_taken,
    output ph1, ph2, sync, ir, t_state, in_reset
  );
endinterface

// File: rtl/k6502_cycle_len.sv
// k6502_cycle_len: combinational opcode to base cycle count and extension flags
// ir   - instruction register
// info - len (2..7), idx_read (+1 on page cross), branch (conditional branch)
// Undocumented opcodes fall back to two cycles without flags.
module k6502_cycle_len
  import k6502_pkg::*;
(
  input  logic [7:0]  ir,
  output cycle_info_t info
);
  always_comb begin
    case (ir)
      8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
        info = '{len: 3'd2, idx_read: 1'b0, branch: 1'b1};
      8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5,
      8'h24, 8'hE4, 8'hC4, 8'hA6, 8'hA4, 8'h86, 8'h84, 8'h4C,
      8'h48, 8'h08:
        info = '{len: 3'd3, idx_read: 1'b0, branch: 1'b0};
      8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5,
      8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED,
      8'h2C, 8'hEC, 8'hCC, 8'hAE, 8'hAC, 8'hB6, 8'hB4, 8'h96,
      8'h94, 8'h8E, 8'h8C, 8'h68, 8'h28:
        info = '{len: 3'd4, idx_read: 1'b0, branch: 1'b0};
      8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'hBD, 8'hDD, 8'hFD,
      8'h19, 8'h39, 8'h59, 8'h79, 8'hB9, 8'hD9, 8'hF9,
      8'hBE, 8'hBC:
        info = '{len: 3'd4, idx_read: 1'b1, branch: 1'b0};
      8'h06, 8'h26, 8'h46, 8'h66, 8'hC6, 8'hE6, 8'h6C, 8'h9D,
      8'h99:
        info = '{len: 3'd5, idx_read: 1'b0, branch: 1'b0};
      8'h11, 8'h31, 8'h51, 8'h71, 8'hB1, 8'hD1, 8'hF1:
        info = '{len: 3'd5, idx_read: 1'b1, branch: 1'b0};
      8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1,
      8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6,
      8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'hCE, 8'hEE,
      8'h20, 8'h40, 8'h60, 8'h91:
        info = '{len: 3'd6, idx_read: 1'b0, branch: 1'b0};
      8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE, 8'h00:
        info = '{len: 3'd7, idx_read: 1'b0, branch: 1'b0};
      default:
        info = '{len: 3'd2, idx_read: 1'b0, branch: 1'b0};
    endcase
  end
endmodule

// File: rtl/k6502_timing.sv
// k6502_timing: 6502-style two-phase clock, reset sequencer and T-state timing
// clk, rst_n (async, active low); bus (k6502_timing_if.slave):
//   in : d, rdy, page_cross, branch_taken   out: ph1, ph2, sync, ir, t_state, in_reset
// Define K6502_RDY_EN to let rdy=0 stall machine cycles; otherwise rdy is ignored.
module k6502_timing
  import k6502_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  k6502_timing_if.slave  bus
);
  cycle_info_t info;
  logic       ph1, ph2, rdy_q, sync, in_rst, rdy_in, adv, ext, last_rst;
  logic [2:0] t, t_nxt, rst_cnt;
  logic [7:0] ir;
  k6502_cycle_len u_len (.ir(ir), .info(info));
`ifdef K6502_RDY_EN
  assign rdy_in = bus.rdy;
`else
  logic unused_rdy;
  assign unused_rdy = bus.rdy;
  assign rdy_in = 1'b1;
`endif
  // rdy is captured on the edge ending ph1; the cycle completes on the edge ending ph2
  assign adv = ph2 && rdy_q;
  assign last_rst = rst_cnt == 3'(RESET_SEQ_LEN - 1);
  // Extension inputs only matter in the one cycle that can extend; T7 never extends
  always_comb begin
    ext = t < T7 && (info.branch ? (t == T2 ? bus.branch_taken : t == T3 && bus.page_cross)
                                 : t == info.len && info.idx_read && bus.page_cross);
    t_nxt = in_rst ? (last_rst ? T1 : T_RESET)
          : t == T1 ? T2
          : (t < info.len || ext) ? t + 3'd1 : T1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph1     <= 1'b0;
      ph2     <= 1'b0;
      rdy_q   <= 1'b0;
      t       <= T_RESET;
      sync    <= 1'b0;
      ir      <= OPC_NOP;
      in_rst  <= 1'b1;
      rst_cnt <= 3'd0;
    end else begin
      ph1 <= !ph1;
      ph2 <= ph1;
      if (ph1) rdy_q <= rdy_in;
      if (adv) begin
        t       <= t_nxt;
        sync    <= t_nxt == T1;
        in_rst  <= in_rst && !last_rst;
        rst_cnt <= (in_rst && !last_rst) ? rst_cnt + 3'd1 : 3'd0;
        if (!in_rst && t == T1) ir <= bus.d;
      end
    end
  end
  assign bus.ph1      = ph1;
  assign bus.ph2      = ph2;
  assign bus.sync     = sync;
  assign bus.ir       = ir;
  assign bus.t_state  = t;
  assign bus.in_reset = in_rst;
endmodule

// File: tb/tb_k6502_timing.sv
// tb_k6502_timing: scoreboard bench for k6502_timing (expected clk-by-clk outputs queued by stimulus)
module tb_k6502_timing;
  import k6502_pkg::*;
`ifdef K6502_RDY_EN
  localparam bit RDY_EN = 1'b1;
`else
  localparam bit RDY_EN = 1'b0;
`endif
  typedef struct packed {
    logic       ph1;
    logic       ph2;
    logic [2:0] t;
    logic       sync;
    logic       inr;
    logic [7:0] ir;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mon_en = 1'b0;
  int nvec = 0;
  int nbad = 0;
  logic [7:0] cur_ir = OPC_NOP;
  obs_t q[$];
  k6502_timing_if bus ();
  k6502_timing dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic obs_t now_obs();
    return '{bus.ph1, bus.ph2, bus.t_state, bus.sync, bus.in_reset, bus.ir};
  endfunction
  function automatic string fmt(input obs_t o);
    return $sformatf("ph1=%b ph2=%b t=%0d sync=%b in_reset=%b ir=%h", o.ph1, o.ph2, o.t, o.sync, o.inr, o.ir);
  endfunction
  always @(negedge clk) begin
    obs_t g, e;
    if (mon_en && (bus.ph1 || bus.ph2)) begin
      g = now_obs();
      nvec++;
      if (q.size() == 0) begin
        nbad++;
        $display("FAIL cycle%0d: got %s, expected no phase activity", nvec, fmt(g));
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          nbad++;
          $display("FAIL cycle%0d: got %s, expected %s", nvec, fmt(g), fmt(e));
        end
      end
    end
  end
  task automatic chk_reset(input string nm);
    obs_t g, e;
    g = now_obs();
    e = '{1'b0, 1'b0, T_RESET, 1'b0, 1'b1, OPC_NOP};
    nvec++;
    if (g !== e) begin
      nbad++;
      $display("FAIL %s: got %s, expected %s", nm, fmt(g), fmt(e));
    end
  endtask
  // One machine cycle, entered 1 time unit after the edge that raises ph1
  task automatic mc(input logic [2:0] t, input logic inr, input logic [7:0] irv, input logic r);
    logic s;
    s = (t == T1) && !inr;
    bus.rdy = r;
    q.push_back('{1'b1, 1'b0, t, s, inr, irv});
    q.push_back('{1'b0, 1'b1, t, s, inr, irv});
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask
  // rdy=0 for the first nst cycles of the sequence; they repeat only when stalling is built in
  task automatic rst_seq(input int nst);
    int left;
    left = nst;
    for (int i = 0; i < RESET_SEQ_LEN; i++) begin
      if (RDY_EN) while (left > 0) begin mc(T_RESET, 1'b1, OPC_NOP, 1'b0); left--; end
      mc(T_RESET, 1'b1, OPC_NOP, left == 0);
      if (left > 0) left--;
    end
  endtask
  task automatic do_reset(input int nst);
    repeat (5) @(negedge clk);
    chk_reset("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_seq(nst);
  endtask
  // len is the hand-computed instruction length; nst stall cycles start at T2
  task automatic instr(input logic [7:0] op, input logic pc, input logic bt, input int len, input int nst);
    int left;
    bus.d = op;
    bus.page_cross = pc;
    bus.branch_taken = bt;
    mc(T1, 1'b0, cur_ir, 1'b1);
    cur_ir = op;
    left = nst;
    for (int t = 2; t <= len; t++) begin
      if (RDY_EN) while (left > 0) begin mc(3'(t), 1'b0, op, 1'b0); left--; end
      mc(3'(t), 1'b0, op, left == 0);
      if (left > 0) left--;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.d = OPC_NOP;
    bus.rdy = 1'b1;
    bus.page_cross = 1'b0;
    bus.branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    #1 chk_reset("reset_assert");
    do_reset(0);
    instr(8'hA9, 1'b1, 1'b1, 2, 0);
    instr(8'hBD, 1'b0, 1'b0, 4, 0);
    instr(8'hBD, 1'b1, 1'b0, 5, 0);
    instr(8'hD0, 1'b1, 1'b0, 2, 0);
    instr(8'hD0, 1'b0, 1'b1, 3, 0);
    instr(8'hD0, 1'b1, 1'b1, 4, 0);
    instr(8'h1E, 1'b1, 1'b1, 7, 0);
    instr(8'h02, 1'b1, 1'b1, 2, 0);
    instr(8'hB1, 1'b1, 1'b0, 6, 0);
    instr(8'hBD, 1'b0, 1'b0, 4, 3);
    instr(8'h00, 1'b0, 1'b0, 7, 0);
    instr(8'hEA, 1'b0, 1'b0, 2, 0);
    bus.d = 8'hBD;
    bus.page_cross = 1'b0;
    bus.branch_taken = 1'b0;
    mc(T1, 1'b0, cur_ir, 1'b1);
    cur_ir = 8'hBD;
    mc(T2, 1'b0, 8'hBD, 1'b1);
    q.push_back('{1'b1, 1'b0, T3, 1'b0, 1'b0, 8'hBD});
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("reset_abort");
    cur_ir = OPC_NOP;
    do_reset(2);
    instr(8'hA9, 1'b0, 1'b0, 2, 0);
    mon_en = 1'b0;
    nvec++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d expected cycles never observed, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/k6502_timing.md
K6502_TIMING -- requirements
Module: k6502_timing

Interface
REQ-001 The module SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  single system clock; every flop in the module updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 d  input  8  external data bus, sampled as the opcode.
REQ-005 rdy  input  1  ready; 0 stalls the current machine cycle (see REQ-021).
REQ-006 page_cross  input  1  adder carry from the datapath; requests the +1 cycle for indexed reads.
REQ-007 branch_taken  input  1  branch condition true; requests the +1 cycle for a taken branch.
REQ-008 ph1, ph2  output  1 each  phase strobes that drive the datapath's ph1/ph2 inputs.
REQ-009 sync  output  1  high during the opcode-fetch cycle.
REQ-010 ir  output  8  instruction register.
REQ-011 t_state  output  3  current cycle: 1..7 = T1..T7; 0 = reset sequence.
REQ-012 in_reset  output  1  high during the reset sequence.

Function
REQ-013 Phases: ph1 and ph2 SHALL alternate; each is high for exactly one clk and never together. ph1 is first after reset.
REQ-014 Machine cycle: one machine cycle is a ph1 clk followed by a ph2 clk. All state advances on the clk edge that ends ph2.
REQ-015 Reset sequence: after rst_n rises, the block runs 7 machine cycles with t_state=0 and in_reset=1, then enters T1.
REQ-016 T1 SHALL assert sync=1. On the edge ending T1 ph2, ir<=d.
REQ-017 Length: sub-module k6502_cycle_len maps ir to a base length N (2..7) and flags idx_read and branch. Undocumented opcodes map to N=2 with no flags.
REQ-018 Sequencing: t_state SHALL advance 1..N. After TN it returns to T1, with no idle cycle.
REQ-019 Index extension: if idx_read=1 and page_cross=1 at ph2 of TN, the block SHALL run one extra cycle before T1.
REQ-020 Branch extension: if branch=1, the rules at ph2 of T2 are:
- branch_taken=0: go to T1.
- branch_taken=1: go to T3.
- At T3, page_cross=1 adds T4.
- The count SHALL saturate at 7; no extension is allowed past T7.
REQ-021 Stall: rdy=0 sampled at ph1 SHALL hold that machine cycle.
- t_state, ir and sync stay frozen.
- ph1/ph2 keep toggling.
- The cycle completes on the first ph2 following a ph1 that sampled rdy=1.
REQ-022 The extension inputs are sampled only in the cycle named in REQ-019/020. They are ignored at all other times.

Reset
REQ-023 While rst_n=0, outputs SHALL be: ph1=0, ph2=0, sync=0, ir=8'hEA (NOP), t_state=0, in_reset=1. The internal reset counter SHALL be 0.
REQ-024 Reset asserted mid-instruction SHALL abort immediately. Deassertion SHALL restart the full 7-cycle sequence of REQ-015.
REQ-025 rdy SHALL also stall reset-sequence cycles, using the REQ-021 rule.

Configuration
REQ-026 With K6502_RDY_EN defined, stall behaviour follows REQ-021/REQ-025.
REQ-027 Without K6502_RDY_EN, the rdy port SHALL remain present but be ignored, and behaviour is as if rdy=1.

Structure
REQ-028 Shared package k6502_pkg SHALL hold:
- T_RESET=3'd0 and T1..T7 constants;
- RESET_SEQ_LEN=7;
- OPC_NOP=8'hEA;
- the cycle_info_t struct {len[2:0], idx_read, branch}.
REQ-029 Sub-module k6502_cycle_len SHALL be purely combinational, mapping ir to cycle_info_t.

Verification
REQ-030 Reset: hold rst_n=0 for 5 clk, then release. Required: 7 cycles (14 clk) with in_reset=1, then t_state=1 with sync=1.
REQ-031 LDA #imm (A9): d=A9 in T1. Required: ir=A9, sequence T1,T2,T1, sync high only in T1.
REQ-032 LDA abs,X (BD): page_cross=0 gives T1..T4. page_cross=1 at T4 ph2 gives T1..T5.
REQ-033 BNE (D0):
- branch_taken=0 gives 2 cycles.
- branch_taken=1 with page_cross=0 gives 3 cycles.
- branch_taken=1 with page_cross=1 gives 4 cycles.
REQ-034 Stall with K6502_RDY_EN: hold rdy=0 for 3 cycles during T2 of BD. Required: t_state stays 2 with phases toggling, and the instruction completes 3 cycles late. Without the macro, the same stimulus SHALL cause no delay.
REQ-035 Reset mid-instruction: drop rst_n at T3 of BD. Required: immediate values per REQ-023, then the 7-cycle sequence restarts.
